// File: rtl/dsi_pixel_pkg.sv
// Shared types and CRC-16 helpers for the DSI pixel packer.
// The CRC items are only referenced when DSI_PIXEL_PACKER_CRC_EN is defined.
package dsi_pixel_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  // Reflected CRC-16 over one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data_byte);
    logic [15:0] c;
    c = crc ^ {8'h00, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_pixel_packer_if.sv
// Pixel-in / word-out stream bundle of the DSI pixel packer, plus its error pulses.
// slave = the packer, master = the surrounding system (DMA source and packet sink).
interface dsi_pixel_packer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic        in_ready;

  logic [31:0] out_data;
  logic        out_valid;
  logic        out_startofline;
  logic        out_endofline;
  logic        out_startofframe;
  logic        out_endofframe;
  logic        out_ready;

  logic        err_resync;
  logic        err_eop;

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_data, out_valid, out_startofline, out_endofline,
           out_startofframe, out_endofframe, err_resync, err_eop
  );

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_data, out_valid, out_startofline, out_endofline,
           out_startofframe, out_endofframe, err_resync, err_eop
  );
endinterface

// File: rtl/dsi_crc16_word.sv
// Combinational CRC-16 update over one 32-bit word, byte0 first.
// Only built when DSI_PIXEL_PACKER_CRC_EN is defined, since only that build instantiates it.
`ifdef DSI_PIXEL_PACKER_CRC_EN
module dsi_crc16_word
  import dsi_pixel_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);
  logic [4:0][15:0] chain;

  assign chain[0] = crc_i;
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign chain[gi+1] = crc16_byte(chain[gi], data_i[8*gi +: 8]);
  end
  assign crc_o = chain[4];
endmodule
`endif

// File: rtl/dsi_pixel_packer.sv
// Repacks XRGB8888 pixels (one per word) into DSI packed RGB888 words with line/frame flags.
// Define DSI_PIXEL_PACKER_CRC_EN to append a {16'h0, crc16} word after every line.
module dsi_pixel_packer
  import dsi_pixel_pkg::*;
#(
  parameter int PIXELS_PER_LINE = 480,
  parameter int LINES_PER_FRAME = 800
) (
  input  logic              clk,
  input  logic              rst_n,
  dsi_pixel_packer_if.slave bus
);
  localparam int PIX_W  = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
  localparam int LINE_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXELS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);
`ifdef DSI_PIXEL_PACKER_CRC_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic [1:0]        ph_q, ph_d, eff_ph;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d, eff_pix;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d, eff_line;
  logic [23:0]       res_q, res_d;
  logic [31:0]       out_data_q, out_data_d, word;
  logic              out_valid_q, out_valid_d;
  logic              sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
  logic              err_resync_q, err_resync_d, err_eop_q, err_eop_d;
  logic              in_ready, accept, out_hs, resync, line_end, frame_end, emit, first_word;
  logic              crc_load, crc_pending, crc_eof;
  logic [15:0]       crc_value;
  logic              unused_in_bits;
  rgb888_t           pix;

  assign pix            = rgb888_t'(bus.in_data[23:0]);
  assign unused_in_bits = ^bus.in_data[31:24];

  assign in_ready = (!out_valid_q || bus.out_ready) && !crc_pending;
  assign accept   = bus.in_valid && in_ready;
  assign out_hs   = out_valid_q && bus.out_ready;

  // A mid-frame SOP makes this pixel p0 of line 0; the counters are viewed as already restarted.
  assign resync     = bus.in_startofpacket && (pix_cnt_q != '0 || line_cnt_q != '0);
  assign eff_ph     = resync ? 2'd0 : ph_q;
  assign eff_pix    = resync ? '0 : pix_cnt_q;
  assign eff_line   = resync ? '0 : line_cnt_q;
  assign line_end   = (eff_pix == PIX_LAST);
  assign frame_end  = line_end && (eff_line == LINE_LAST);
  assign emit       = accept && (eff_ph != 2'd0);
  assign first_word = (eff_pix == PIX_W'(1));

  // Wire byte order is R, G, B; residue byte 0 is the oldest pending byte.
  always_comb begin
    word  = '0;
    res_d = res_q;
    case (eff_ph)
      2'd0: word = '0;
      2'd1: word = {pix.r, res_q[23:0]};
      2'd2: word = {pix.g, pix.r, res_q[15:0]};
      default: word = {pix.b, pix.g, pix.r, res_q[7:0]};
    endcase
    if (accept) begin
      case (eff_ph)
        2'd0: res_d = {pix.b, pix.g, pix.r};
        2'd1: res_d = {8'h00, pix.b, pix.g};
        2'd2: res_d = {16'h0000, pix.b};
        default: res_d = '0;
      endcase
    end
  end

  always_comb begin
    ph_d       = ph_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    if (accept) begin
      ph_d       = eff_ph + 2'd1;
      pix_cnt_d  = line_end ? '0 : eff_pix + PIX_W'(1);
      line_cnt_d = !line_end ? eff_line : (eff_line == LINE_LAST) ? '0 : eff_line + LINE_W'(1);
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sol_d       = sol_q;
    eol_d       = eol_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    if (out_hs) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      sol_d       = first_word;
      sof_d       = first_word && (eff_line == '0);
      eol_d       = !CRC_EN && line_end;
      eof_d       = !CRC_EN && frame_end;
    end else if (crc_load) begin
      out_valid_d = 1'b1;
      out_data_d  = {16'h0000, crc_value};
      sol_d       = 1'b0;
      sof_d       = 1'b0;
      eol_d       = 1'b1;
      eof_d       = crc_eof;
    end
  end

  assign err_resync_d = accept && resync;
  assign err_eop_d    = accept && (bus.in_endofpacket != frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q         <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      res_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      sol_q        <= 1'b0;
      eol_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      err_resync_q <= 1'b0;
      err_eop_q    <= 1'b0;
    end else begin
      ph_q         <= ph_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      res_q        <= res_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      sol_q        <= sol_d;
      eol_q        <= eol_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      err_resync_q <= err_resync_d;
      err_eop_q    <= err_eop_d;
    end
  end

`ifdef DSI_PIXEL_PACKER_CRC_EN
  logic [15:0] crc_q, crc_d, crc_base, crc_step;
  logic        crc_pending_q, crc_pending_d, crc_eof_q, crc_eof_d, crc_due_q, crc_due_d;

  // The first word of a line restarts the CRC; crc_due marks the last payload word in the output reg.
  assign crc_base = first_word ? CRC16_INIT : crc_q;

  dsi_crc16_word u_crc16_word (
    .crc_i  (crc_base),
    .data_i (word),
    .crc_o  (crc_step)
  );

  always_comb begin
    crc_d         = crc_q;
    crc_pending_d = crc_pending_q;
    crc_eof_d     = crc_eof_q;
    crc_due_d     = crc_due_q;
    if (out_hs && crc_due_q) begin
      crc_pending_d = 1'b1;
      crc_due_d     = 1'b0;
    end else if (out_hs && crc_pending_q) begin
      crc_pending_d = 1'b0;
    end
    if (emit) begin
      crc_d     = crc_step;
      crc_due_d = line_end;
      crc_eof_d = frame_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q         <= CRC16_INIT;
      crc_pending_q <= 1'b0;
      crc_eof_q     <= 1'b0;
      crc_due_q     <= 1'b0;
    end else begin
      crc_q         <= crc_d;
      crc_pending_q <= crc_pending_d;
      crc_eof_q     <= crc_eof_d;
      crc_due_q     <= crc_due_d;
    end
  end

  assign crc_load    = out_hs && crc_due_q;
  assign crc_pending = crc_pending_q;
  assign crc_value   = crc_q;
  assign crc_eof     = crc_eof_q;
`else
  assign crc_load    = 1'b0;
  assign crc_pending = 1'b0;
  assign crc_value   = '0;
  assign crc_eof     = 1'b0;
`endif

  assign bus.in_ready         = in_ready;
  assign bus.out_data         = out_data_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_startofline  = sol_q;
  assign bus.out_endofline    = eol_q;
  assign bus.out_startofframe = sof_q;
  assign bus.out_endofframe   = eof_q;
  assign bus.err_resync       = err_resync_q;
  assign bus.err_eop          = err_eop_q;
endmodule

// File: doc/dsi_pixel_packer.md
# dsi_pixel_packer

Downstream of the AXI-read stream DMA. Consumes its 32-bit XRGB8888 pixel stream, one pixel per word, and repacks it into the DSI packed RGB888 byte stream: 4 pixels become 3 output words. It adds line and frame framing, and optionally a trailing CRC-16 word per line, for the DSI long-packet assembler.

## Interface
- PIXELS_PER_LINE, 480, active pixels per line; must be a multiple of 4.
- LINES_PER_FRAME, 800, lines per frame.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  32  pixel; R=[23:16], G=[15:8], B=[7:0], [31:24] ignored.
- in_valid  in  1  pixel valid.
- in_startofpacket  in  1  first pixel of frame.
- in_endofpacket  in  1  last pixel of frame (checked only).
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- out_data  out  32  packed bytes, byte0 = [7:0].
- out_valid  out  1  word valid.
- out_startofline  out  1  first word of a line.
- out_endofline  out  1  last word of a line.
- out_startofframe  out  1  first word of a frame.
- out_endofframe  out  1  last word of a frame.
- out_ready  in  1  sink accepts the word when valid && ready.
- err_resync  out  1  one-cycle pulse: SOP arrived mid-frame.
- err_eop  out  1  one-cycle pulse: EOP mismatch.

## Operation
- Pixel accept occurs when in_valid && in_ready. in_ready = (!out_valid || out_ready) && !crc_pending.
- Phase counter ph (2 bits) cycles 0..3 per accepted pixel. The residue register holds up to 3 bytes. Byte order per pixel on the wire is R, G, B.
  - ph0: store {B,G,R} of p0. No output.
  - ph1: emit {p1.R, p0.B, p0.G, p0.R}. Store p1.G, p1.B.
  - ph2: emit {p2.G, p2.R, p1.B, p1.G}. Store p2.B.
  - ph3: emit {p3.B, p3.G, p3.R, p2.B}.
- pix_cnt counts 0..PIXELS_PER_LINE-1 and wraps. line_cnt counts 0..LINES_PER_FRAME-1 and wraps at the end of the frame.
- Flags:
  - out_startofline is set on the word produced at pix_cnt==1.
  - out_startofframe is additionally set on that word when line_cnt==0.
  - out_endofline is set on the word produced at pix_cnt==PIXELS_PER_LINE-1, or on the CRC word when CRC is enabled.
  - out_endofframe is set on that same end-of-line word when line_cnt==LINES_PER_FRAME-1.
- Resync: SOP accepted while pix_cnt!=0 or line_cnt!=0:
  - err_resync pulses.
  - The residue is discarded.
  - ph, pix_cnt and line_cnt restart with this pixel as p0 of line 0.
  - The partial line already emitted gets no endofline.
- SOP at pix_cnt==0 && line_cnt==0 is normal. A missing SOP at that point is not an error; the frame starts anyway.
- err_eop pulses when in_endofpacket is accepted on any pixel other than the last pixel of the frame, or when the last pixel of the frame is accepted without in_endofpacket. Counting is unaffected.

## Timing
- Reset values: out_valid=0, out_data=0, all out_* flags 0, err_*=0, ph=0, pix_cnt=0, line_cnt=0, crc_pending=0. in_ready=1 after reset.
- Latency: accepted pixel in ph1..3 → out_valid in the next cycle (registered output stage).
- Throughput: 1 pixel per cycle with out_ready held high; 3 words per 4 cycles.
- out_valid with out_data and flags stays stable until out_ready. It must never drop without a handshake.
- Simultaneous output handshake and new pixel in the same cycle: the output register reloads and there is no bubble.
- Reset mid-line clears everything. The partial line is lost.

## Configuration
- Macro: DSI_PIXEL_PACKER_CRC_EN.
- Defined:
  - A CRC-16 is computed over the line's payload bytes, byte0 first, each byte LSB first. Parameters: reflected poly 0x8408, init 0xFFFF, reinit at each line.
  - After the last payload word of a line is handshaken, crc_pending=1 and one extra word {16'h0, crc} is emitted with out_endofline (and out_endofframe if applicable).
  - in_ready=0 while crc_pending. It clears on that word's handshake.
  - Throughput per line becomes 3·PIXELS_PER_LINE/4 + 1 words.
- Undefined: no CRC logic and no extra word. crc_pending is tied to 0.

## Structure
- Package dsi_pixel_pkg:
  - rgb888_t struct (r, g, b bytes).
  - CRC16_POLY_REFL=16'h8408 and CRC16_INIT=16'hFFFF.
  - Function crc16_byte(crc, byte).
- Sub-module dsi_crc16_word: combinational 32-bit (4-byte) CRC update step. Instantiated only under the macro.

## Test plan
- PIXELS_PER_LINE=4, pixels 0x00112233, 0x00445566, 0x00778899, 0x00AABBCC, out_ready=1 → words 0x44332211, 0x88776655, 0xCCBBAA99. sol on the first word, eol on the third, next-cycle latency.
- 2×4 frame, random out_ready stalls → output identical to the unstalled run, data held stable during stalls, no pixel lost or duplicated. sof on word 0, eof on word 5.
- SOP injected at pixel 2 of line 0 → err_resync pulse. One orphan word without eol. Next 4 pixels produce a complete line with sof+sol.
- in_endofpacket on pixel 3 of line 0 in a 2-line frame → err_eop pulse, framing unchanged.
- With DSI_PIXEL_PACKER_CRC_EN, line of 4 pixels all 0x00000000 → 3 zero words plus a CRC word matching the golden CRC-16 of 12 zero bytes, eol only on the CRC word. in_ready low exactly while that word is pending.
- Assert rst_n low after 2 pixels of a line → all outputs at reset values. The next frame packs correctly from p0.
